// File: rtl/hamming74_enc_stream.sv
// hamming74_enc_stream: byte-to-Hamming(7,4)+parity codeword streamer.
// Splits each accepted byte into two nibbles and emits one registered
// SECDED codeword per nibble over a valid/ready handshake.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_byte, i_valid     upstream byte and its valid
//   o_ready             byte accepted this cycle when i_valid & o_ready
//   o_code, o_parity    codeword {d3,d2,d1,p4,d0,p2,p1} and even parity
//   o_valid, i_ready    downstream handshake
//   o_word_cnt          codewords transferred, wraps silently
//
// Optional build macro HAMMING_ERR_INJECT_EN adds i_inj_en / i_inj_mask:
// a pulse arms a one-shot XOR mask applied to the next loaded codeword.
module hamming74_enc_stream #(
  parameter int unsigned LSB_FIRST = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [7:0]       i_byte,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [6:0]       o_code,
  output logic             o_parity,
  output logic             o_valid,
  input  logic             i_ready,
`ifdef HAMMING_ERR_INJECT_EN
  input  logic             i_inj_en,
  input  logic [7:0]       i_inj_mask,
`endif
  output logic [CNT_W-1:0] o_word_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND_A = 2'd1,
    SEND_B = 2'd2
  } state_e;

  state_e           state_q;
  logic [3:0]       nib2_q;
  logic [6:0]       code_q;
  logic             par_q;
  logic             valid_q;
  logic [CNT_W-1:0] cnt_q;

  logic             xfer;
  logic             load;
  logic [3:0]       nib1;
  logic [3:0]       nib2;
  logic [7:0]       inj_d;
  logic [7:0]       cw1_d;
  logic [7:0]       cw2_d;

  // Codeword bit order {d3,d2,d1,p4,d0,p2,p1}.
  function automatic logic [6:0] enc(input logic [3:0] d);
    logic p1;
    logic p2;
    logic p4;
    p1 = d[0] ^ d[1] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p4 = d[1] ^ d[2] ^ d[3];
    return {d[3], d[2], d[1], p4, d[0], p2, p1};
  endfunction

  // Even parity over all 8 bits, so the parity bit is the XOR of the code.
  function automatic logic [7:0] enc_par(input logic [3:0] d);
    logic [6:0] c;
    c = enc(d);
    return {^c, c};
  endfunction

  assign o_code     = code_q;
  assign o_parity   = par_q;
  assign o_valid    = valid_q;
  assign o_word_cnt = cnt_q;

  assign xfer = valid_q & i_ready;

  always_comb begin
    o_ready = 1'b0;
    unique case (state_q)
      IDLE:    o_ready = 1'b1;
      SEND_A:  o_ready = 1'b0;
      SEND_B:  o_ready = i_ready;
      default: o_ready = 1'b0;
    endcase
  end

  assign nib1 = (LSB_FIRST != 0) ? i_byte[3:0] : i_byte[7:4];
  assign nib2 = (LSB_FIRST != 0) ? i_byte[7:4] : i_byte[3:0];

  // Any cycle the output registers take a fresh codeword.
  assign load = (i_valid & o_ready) | ((state_q == SEND_A) & i_ready);

`ifdef HAMMING_ERR_INJECT_EN
  logic       inj_pend_q;
  logic [7:0] inj_mask_q;

  assign inj_d = inj_pend_q ? inj_mask_q : 8'h00;

  // A pulse coinciding with a load arms the following load; the current
  // load consumes whatever was already pending.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      inj_pend_q <= 1'b0;
      inj_mask_q <= 8'h00;
    end else if (i_inj_en) begin
      inj_pend_q <= 1'b1;
      inj_mask_q <= i_inj_mask;
    end else if (load) begin
      inj_pend_q <= 1'b0;
    end
  end
`else
  assign inj_d = 8'h00;
`endif

  assign cw1_d = enc_par(nib1) ^ inj_d;
  assign cw2_d = enc_par(nib2_q) ^ inj_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      nib2_q  <= 4'h0;
      code_q  <= 7'h00;
      par_q   <= 1'b0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (xfer) begin
        cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      unique case (state_q)
        IDLE: begin
          if (i_valid) begin
            nib2_q           <= nib2;
            {par_q, code_q}  <= cw1_d;
            valid_q          <= 1'b1;
            state_q          <= SEND_A;
          end
        end
        SEND_A: begin
          if (i_ready) begin
            {par_q, code_q} <= cw2_d;
            state_q         <= SEND_B;
          end
        end
        SEND_B: begin
          if (i_ready) begin
            if (i_valid) begin
              // Back-to-back byte: no bubble between codewords.
              nib2_q          <= nib2;
              {par_q, code_q} <= cw1_d;
              state_q         <= SEND_A;
            end else begin
              valid_q <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hamming74_enc_stream.sv
// tb_hamming74_enc_stream: directed and random checks of the codeword
// streamer against a position-based Hamming reference and a queue model.
module tb_hamming74_enc_stream;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] byte_i = 8'h00;
  logic       vld_i = 1'b0;
  logic       rdy_i = 1'b0;
  logic       inj_en = 1'b0;
  logic [7:0] inj_mask = 8'h00;

  logic        ordy, opar, ovld;
  logic [6:0]  ocode;
  logic [15:0] ocnt;
  logic        ordy2, opar2, ovld2;
  logic [6:0]  ocode2;
  logic [3:0]  ocnt2;

  always #5 clk = ~clk;

  hamming74_enc_stream #(.LSB_FIRST(1), .CNT_W(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_byte(byte_i), .i_valid(vld_i),
    .o_ready(ordy), .o_code(ocode), .o_parity(opar), .o_valid(ovld),
    .i_ready(rdy_i),
`ifdef HAMMING_ERR_INJECT_EN
    .i_inj_en(inj_en), .i_inj_mask(inj_mask),
`endif
    .o_word_cnt(ocnt)
  );

  hamming74_enc_stream #(.LSB_FIRST(0), .CNT_W(4)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_byte(byte_i), .i_valid(vld_i),
    .o_ready(ordy2), .o_code(ocode2), .o_parity(opar2), .o_valid(ovld2),
    .i_ready(rdy_i),
`ifdef HAMMING_ERR_INJECT_EN
    .i_inj_en(inj_en), .i_inj_mask(inj_mask),
`endif
    .o_word_cnt(ocnt2)
  );

  int         total = 0;
  int         bad = 0;
  logic [7:0] q1[$];
  logic [7:0] q2[$];
  int         cnt_m = 0;
  bit         hold_f = 0;
  logic [7:0] hold_v = 8'h00;
  bit         pend_m = 0;
  logic [7:0] mask_m = 8'h00;
  bit         acc = 0;

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Classic positional Hamming: data at positions 3,5,6,7; parity at
  // position k covers every data position whose index has bit k set.
  function automatic logic [7:0] ref_cw(input logic [3:0] d);
    logic [7:1] p;
    logic       par;
    p    = '0;
    p[3] = d[0];
    p[5] = d[1];
    p[6] = d[2];
    p[7] = d[3];
    for (int k = 1; k <= 4; k = k * 2)
      for (int j = 3; j <= 7; j++)
        if ((j & k) != 0 && j != k) p[k] = p[k] ^ p[j];
    par = ($countones(p) % 2) == 1;
    return {par, p};
  endfunction

  function automatic logic [7:0] take_mask();
    logic [7:0] m;
    m = pend_m ? mask_m : 8'h00;
    pend_m = 0;
    return m;
  endfunction

  task automatic check_obs();
    int         n;
    logic       er;
    logic [7:0] m;
    n  = q1.size();
    er = (n == 0) ? 1'b1 : (n == 1) ? rdy_i : 1'b0;
    chk("valid", ovld, n != 0);
    chk("valid2", ovld2, n != 0);
    chk("ready", ordy, er);
    chk("ready2", ordy2, er);
    chk("cnt", ocnt, cnt_m[15:0]);
    chk("cnt4", ocnt2, cnt_m[3:0]);
    if (hold_f) chk("hold", {opar, ocode}, hold_v);
    hold_f = ovld && !rdy_i;
    hold_v = {opar, ocode};
    acc = 0;
    if (ovld && rdy_i) begin
      if (n == 0) chk("xfer_q", n, 1);
      else begin
        chk("cw", {opar, ocode}, q1.pop_front());
        chk("cw2", {opar2, ocode2}, q2.pop_front());
        cnt_m++;
        if (n == 2) begin
          m = take_mask();
          q1[0] = q1[0] ^ m;
          q2[0] = q2[0] ^ m;
        end
      end
    end
    if (vld_i && er) begin
      acc = 1;
      m = take_mask();
      q1.push_back(ref_cw(byte_i[3:0]) ^ m);
      q1.push_back(ref_cw(byte_i[7:4]));
      q2.push_back(ref_cw(byte_i[7:4]) ^ m);
      q2.push_back(ref_cw(byte_i[3:0]));
    end
    if (inj_en) begin
      pend_m = 1;
      mask_m = inj_mask;
    end
  endtask

  task automatic step(input logic v, input logic [7:0] b, input logic r);
    @(negedge clk);
    vld_i  = v;
    byte_i = b;
    rdy_i  = r;
    #1;
    check_obs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst    = 1'b1;
    vld_i  = 1'b0;
    rdy_i  = 1'b0;
    inj_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    q1.delete();
    q2.delete();
    cnt_m  = 0;
    hold_f = 0;
    pend_m = 0;
    #1;
    chk("rst_valid", ovld, 0);
    chk("rst_ready", ordy, 1);
    chk("rst_cnt", ocnt, 0);
    chk("rst_cw", {opar, ocode}, 0);
    chk("rst_cnt4", ocnt2, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && q1.size() != 0; i++) step(1'b0, 8'h00, 1'b1);
    chk("drain", q1.size(), 0);
    step(1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    logic [7:0] cur;
    bit         have;

    do_reset();

    // Single byte, free-flowing sink.
    step(1'b1, 8'hA5, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    chk("t1_cw0", {opar, ocode}, 8'h2D);
    step(1'b0, 8'h00, 1'b1);
    chk("t1_cw1", {opar, ocode}, 8'hD2);
    step(1'b0, 8'h00, 1'b1);
    chk("t1_cnt", ocnt, 2);

    // Back-to-back bytes, no bubble.
    step(1'b1, 8'h00, 1'b1);
    step(1'b1, 8'hFF, 1'b1);
    chk("t2_cw0", {opar, ocode}, 8'h00);
    step(1'b1, 8'hFF, 1'b1);
    chk("t2_cw1", {opar, ocode}, 8'h00);
    chk("t2_rdyB", ordy, 1);
    step(1'b0, 8'h00, 1'b1);
    chk("t2_cw2", {opar, ocode}, 8'hFF);
    step(1'b0, 8'h00, 1'b1);
    chk("t2_cw3", {opar, ocode}, 8'hFF);
    drain();

    // Back-pressure during first codeword.
    step(1'b1, 8'hA5, 1'b0);
    repeat (5) begin
      step(1'b0, 8'h00, 1'b0);
      chk("t3_hold", {opar, ocode}, 8'h2D);
      chk("t3_cnt", ocnt, 6);
    end
    drain();

    // Counter wrap on the 4-bit instance.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      acc = 0;
      for (int t = 0; t < 6 && !acc; t++) step(1'b1, 8'(i * 37), 1'b1);
      chk("t5_acc", acc, 1);
    end
    drain();
    chk("t5_cnt4", ocnt2, 2);
    chk("t5_cnt", ocnt, 18);

    // Reset while in the second-nibble state.
    step(1'b1, 8'h3C, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    do_reset();
    repeat (3) step(1'b0, 8'h00, 1'b1);

    // Random traffic.
    have = 0;
    cur  = 8'h00;
    for (int c = 0; c < 600; c++) begin
      if (!have) begin
        cur  = 8'($urandom);
        have = 1;
      end
      step($urandom_range(0, 3) != 0, cur, $urandom_range(0, 3) != 0);
      if (acc) have = 0;
    end
    drain();

`ifdef HAMMING_ERR_INJECT_EN
    do_reset();
    inj_en   = 1'b1;
    inj_mask = 8'h04;
    step(1'b0, 8'h00, 1'b1);
    inj_en = 1'b0;
    step(1'b1, 8'hA5, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    chk("t6_inj1", {opar, ocode}, 8'h29);
    step(1'b0, 8'h00, 1'b1);
    chk("t6_clean", {opar, ocode}, 8'hD2);
    drain();
    inj_en   = 1'b1;
    inj_mask = 8'h0C;
    step(1'b0, 8'h00, 1'b1);
    inj_en = 1'b0;
    step(1'b1, 8'hA5, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    chk("t6_inj2", {opar, ocode}, 8'h21);
    drain();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
